// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ready handshake, one-entry skid buffer, redirect flush.
// Optional misaligned-redirect fault and HALT state enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] p4,
    output logic        ins_valid,
    output logic [31:0] pc,
    output logic        fetch_fault
);

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StFetch, StFull, StDrop, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StFull, StDrop} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] p4_q, p4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_ins_q, skid_ins_d;
    logic [31:0] skid_p4_q, skid_p4_d;

    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic        done;
    logic        redirect_ok;

`ifdef IF_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
    logic        misaligned;

    assign tgt         = target;
    assign misaligned  = |target[1:0];
    // Once faulted, the unit ignores redirects until clr.
    assign redirect_ok = redirect & ~fault_q;
`else
    assign tgt         = target & 32'hFFFF_FFFC;
    assign redirect_ok = redirect;
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign done     = req_q & imem_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        ins_d      = ins_q;
        p4_d       = p4_q;
        valid_d    = valid_q;
        skid_ins_d = skid_ins_q;
        skid_p4_d  = skid_p4_q;
`ifdef IF_ALIGN_CHECK_EN
        fault_d    = fault_q;
`endif

        if (redirect_ok) begin
            pc_d    = tgt;
            valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            if (misaligned) begin
                fault_d = 1'b1;
                if (req_q && !imem_ready) begin
                    state_d = StDrop;
                end else begin
                    state_d = StHalt;
                    req_d   = 1'b0;
                end
            end else
`endif
            if (req_q && !imem_ready) begin
                // Outstanding request keeps its address until memory completes it.
                state_d = StDrop;
            end else begin
                state_d = StFetch;
                req_d   = 1'b1;
                addr_d  = tgt;
            end
        end else begin
            if (valid_q && !stall) begin
                valid_d = 1'b0;
            end

            unique case (state_q)
                StFetch: begin
                    req_d = 1'b1;
                    if (done) begin
                        if (!valid_q || !stall) begin
                            ins_d   = imem_rdata;
                            p4_d    = pc_plus4;
                            valid_d = 1'b1;
                        end else begin
                            skid_ins_d = imem_rdata;
                            skid_p4_d  = pc_plus4;
                            state_d    = StFull;
                            req_d      = 1'b0;
                        end
                        pc_d   = pc_plus4;
                        addr_d = pc_plus4;
                    end
                end
                StFull: begin
                    if (!stall) begin
                        ins_d   = skid_ins_q;
                        p4_d    = skid_p4_q;
                        valid_d = 1'b1;
                        state_d = StFetch;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                StDrop: begin
                    if (done) begin
`ifdef IF_ALIGN_CHECK_EN
                        if (fault_q) begin
                            state_d = StHalt;
                            req_d   = 1'b0;
                        end else begin
                            state_d = StFetch;
                            addr_d  = pc_q;
                        end
`else
                        state_d = StFetch;
                        addr_d  = pc_q;
`endif
                    end
                end
`ifdef IF_ALIGN_CHECK_EN
                StHalt: begin
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
`endif
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            ins_q      <= 32'd0;
            p4_q       <= 32'd0;
            valid_q    <= 1'b0;
            skid_ins_q <= 32'd0;
            skid_p4_q  <= 32'd0;
`ifdef IF_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            ins_q      <= ins_d;
            p4_q       <= p4_d;
            valid_q    <= valid_d;
            skid_ins_q <= skid_ins_d;
            skid_p4_q  <= skid_p4_d;
`ifdef IF_ALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ins       = ins_q;
    assign p4        = p4_q;
    assign ins_valid = valid_q;
    assign pc        = pc_q;
`ifdef IF_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based fetch model checked every cycle, plus directed literal checks.
module tb_if_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        clr, stall, redirect, imem_ready;
    logic [31:0] target, imem_rdata;
    logic        imem_req, ins_valid, fetch_fault;
    logic [31:0] imem_addr, ins, p4, pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .clr        (clr),
        .stall      (stall),
        .redirect   (redirect),
        .target     (target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .p4         (p4),
        .ins_valid  (ins_valid),
        .pc         (pc),
        .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the fetch pipeline as a queue of delivered {ins,p4}; front is the output slot.
    bit          m_live = 1'b0;
    bit          m_req, m_drop, m_fault, m_halt;
    logic [31:0] m_pc, m_addr, m_ins, m_p4;
    logic [63:0] m_q[$];

    task automatic model_step();
        bit          done;
        logic [31:0] tgt;
        if (clr) begin
            m_live = 1'b1;
            m_pc = RPC; m_addr = RPC; m_ins = 32'd0; m_p4 = 32'd0;
            m_q.delete();
            m_req = 1'b0; m_drop = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
            return;
        end
        if (!m_live) return;
        done = m_req && imem_ready;
        if (redirect && !m_fault) begin
            m_q.delete();
`ifdef IF_ALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_pc = target;
                if (m_req && !imem_ready) m_drop = 1'b1;
                else begin m_req = 1'b0; m_drop = 1'b0; m_halt = 1'b1; end
                return;
            end
`endif
            tgt = {target[31:2], 2'b00};
            m_pc = tgt;
            if (m_req && !imem_ready) m_drop = 1'b1;
            else begin m_drop = 1'b0; m_req = 1'b1; m_addr = tgt; end
            return;
        end
        if (m_halt) return;
        if (m_q.size() > 0 && !stall) begin
            void'(m_q.pop_front());
            if (m_q.size() > 0) begin m_ins = m_q[0][63:32]; m_p4 = m_q[0][31:0]; end
        end
        if (done) begin
            if (m_drop) begin
                m_drop = 1'b0;
                if (m_fault) begin m_req = 1'b0; m_halt = 1'b1; end
                else m_addr = m_pc;
            end else begin
                if (m_q.size() == 0) begin m_ins = imem_rdata; m_p4 = m_addr + 32'd4; end
                m_q.push_back({imem_rdata, m_addr + 32'd4});
                m_pc = m_addr + 32'd4;
                m_addr = m_pc;
                m_req = (m_q.size() < 2);
            end
        end else if (!m_req && m_q.size() < 2) begin
            m_req = 1'b1;
            m_addr = m_pc;
        end
    endtask

    always @(posedge clk) model_step();

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
            chk("imem_addr", imem_addr, m_addr);
            chk("ins_valid", {31'd0, ins_valid}, {31'd0, (m_q.size() > 0)});
            chk("ins", ins, m_ins);
            chk("p4", p4, m_p4);
            chk("pc", pc, m_pc);
            chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        end
    end

    task automatic mem(input bit r);
        imem_ready = r;
        imem_rdata = r ? memword(imem_addr) : $urandom;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        mem(imem_ready);
    endtask

    initial begin
        clr = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'd0;
        imem_ready = 1'b1; imem_rdata = 32'd0;

        // Reset and zero-wait streaming from 0x100.
        cycle();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_p4", p4, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        cycle();
        clr = 1'b0;
        cycle();
        chk("e1_req", {31'd0, imem_req}, 32'd1);
        chk("e1_addr", imem_addr, 32'h100);
        chk("e1_valid", {31'd0, ins_valid}, 32'd0);
        cycle();
        chk("e2_valid", {31'd0, ins_valid}, 32'd1);
        chk("e2_p4", p4, 32'h104);
        chk("e2_ins", ins, memword(32'h100));
        chk("e2_addr", imem_addr, 32'h104);
        cycle();
        chk("e3_p4", p4, 32'h108);
        chk("e3_addr", imem_addr, 32'h108);

        // Redirect while the request to 0x108 waits.
        mem(1'b0);
        cycle();
        chk("wait_valid", {31'd0, ins_valid}, 32'd0);
        chk("wait_p4", p4, 32'h108);
        redirect = 1'b1; target = 32'h200;
        cycle();
        redirect = 1'b0;
        chk("drop_addr", imem_addr, 32'h108);
        chk("drop_pc", pc, 32'h200);
        cycle();
        chk("drop_hold", imem_addr, 32'h108);
        mem(1'b1);
        cycle();
        chk("post_drop_addr", imem_addr, 32'h200);
        chk("post_drop_valid", {31'd0, ins_valid}, 32'd0);
        cycle();
        chk("redir_p4", p4, 32'h204);
        chk("redir_ins", ins, memword(32'h200));

        // Misaligned redirect coincident with ready.
        redirect = 1'b1; target = 32'h202;
        cycle();
        redirect = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, ins_valid}, 32'd0);
        cycle();
        chk("mis_sticky", {31'd0, fetch_fault}, 32'd1);
        chk("mis_halt_req", {31'd0, imem_req}, 32'd0);
`else
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_valid", {31'd0, ins_valid}, 32'd0);
        cycle();
        chk("mis_p4", p4, 32'h204);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
`endif

        // Stall with skid buffer.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        cycle();
        chk("sk_p4_i0", p4, 32'h104);
        stall = 1'b1;
        cycle();
        chk("sk_full_req", {31'd0, imem_req}, 32'd0);
        chk("sk_full_p4", p4, 32'h104);
        cycle(); cycle(); cycle();
        chk("sk_hold_p4", p4, 32'h104);
        chk("sk_hold_valid", {31'd0, ins_valid}, 32'd1);
        stall = 1'b0;
        cycle();
        chk("sk_i1_p4", p4, 32'h108);
        chk("sk_i1_ins", ins, memword(32'h104));
        chk("sk_resume_addr", imem_addr, 32'h108);
        cycle();
        chk("sk_next_p4", p4, 32'h10C);

        // Redirect during FULL discards both output and skid.
        stall = 1'b1;
        cycle();
        redirect = 1'b1; target = 32'h300;
        cycle();
        redirect = 1'b0; stall = 1'b0;
        chk("full_redir_valid", {31'd0, ins_valid}, 32'd0);
        chk("full_redir_addr", imem_addr, 32'h300);
        cycle();
        chk("full_redir_p4", p4, 32'h304);

        // Randomized traffic with wait-state modes, stalls, redirects (incl. wrap) and resets.
        begin
            int mode = 0;
            int phase = 0;
            for (int i = 0; i < 4000; i++) begin
                if (i % 250 == 0) mode = $urandom_range(0, 2);
                phase++;
                clr      = ($urandom % 400 == 0);
                stall    = ($urandom % 10 < 3);
                redirect = ($urandom % 16 == 0);
                case ($urandom % 4)
                    0: target = 32'hFFFF_FFF0 + 32'($urandom % 4) * 32'd4;
                    1: target = $urandom;
                    default: target = {20'd0, 10'($urandom), 2'b00};
                endcase
                case (mode)
                    0: mem(1'b1);
                    1: mem(phase % 3 == 0);
                    default: mem($urandom % 2 == 1);
                endcase
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline CPU. Holds the PC and issues word fetches to instruction memory over a req/ready handshake. Delivers each fetched instruction and its PC+4 to the IF/ID pipeline latch with a valid flag. Absorbs ID-stage stalls with a one-entry skid buffer and applies branch/jump redirects, discarding any fetch already in flight.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- clr  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- stall  in  1  ID hazard stall; the IF/ID latch does not accept this cycle.
- redirect  in  1  taken branch/jump from ID; flushes fetch.
- target  in  32  new PC when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch word address, held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- ins  out  32  instruction to IF/ID latch.
- p4  out  32  PC+4 of ins.
- ins_valid  out  1  ins/p4 valid; handed off on an edge with ins_valid=1 and stall=0.
- pc  out  32  current fetch PC (next address to request).
- fetch_fault  out  1  misaligned redirect fault (see Configuration).

## Operation

- Reset (clr=1 at edge): pc=RESET_PC, imem_addr=RESET_PC, ins=0, p4=0, ins_valid=0, skid empty, fetch_fault=0, state=FETCH. imem_req is a registered output, reset value 0.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready:
    - Output slot free (ins_valid=0, or stall=0): ins<=rdata, p4<=pc+4, ins_valid<=1, pc<=pc+4, stay FETCH.
    - Output slot held (ins_valid=1 and stall=1): rdata and pc+4 go to the skid buffer, pc<=pc+4, go to FULL.
  - FULL: imem_req=0. When stall=0, the output is handed off and reloaded from skid (ins_valid stays 1), skid emptied, go to FETCH.
  - DROP: imem_req=1, imem_addr held at the stale address. On imem_ready, data is discarded and state goes to FETCH (imem_addr<=pc).
  - HALT: only with the fault macro. imem_req=0, ins_valid=0 until clr.
- Handoff with ins_valid=1, stall=0 and no new data: ins_valid<=0; ins and p4 keep their value.
- Redirect (priority over stall and imem_ready):
  - pc<=target; ins_valid<=0; skid emptied.
  - If imem_req=1 and imem_ready=0 at the edge, go to DROP. Otherwise go to FETCH with imem_addr<=target.
  - Redirect coincident with imem_ready: the returned data is discarded.
- Redirect while in DROP: pc<=target and state stays DROP.
- PC arithmetic: unsigned 32-bit, pc+4 wraps from 32'hFFFF_FFFC to 0.
- clr mid-request: the request is abandoned; memory must tolerate the dropped req.

## Timing

- Zero-wait memory (ready in the same cycle as req): one instruction per cycle. First ins_valid=1 at the 2nd edge after clr falls (1 edge to assert req, 1 to capture).
- N wait cycles: ins_valid rises N+1 edges after req first asserts.
- Redirect to first new valid instruction with zero-wait memory: 2 edges from the FETCH state, plus the remaining wait from DROP.
- The IF/ID latch uses enable = ~stall and flush = redirect. ins_valid is advisory for bubble insertion.

## Configuration

- IF_ALIGN_CHECK_EN defined:
  - Redirect with target[1:0]≠0 sets fetch_fault=1 (sticky until clr).
  - The state goes to HALT, or to DROP then HALT if a fetch is outstanding.
  - ins_valid is forced to 0.
- Not defined: fetch_fault is tied to 0, target[1:0] is ignored (forced to 2'b00), and there is no HALT state.

## Test plan

- Reset: clr=1 for 2 cycles, RESET_PC=32'h100, zero-wait memory -> imem_addr sequence 100,104,108. ins_valid rises 2 edges after clr falls; p4 values 104,108,10C.
- Wait states: imem_ready only every 3rd cycle -> imem_addr stable while waiting, one ins_valid per ready, no duplicate or skipped addresses.
- Stall with skid: stall=1 for 4 cycles while ins=I0 valid -> I0 held, I1 captured into skid, imem_req=0. stall drops -> I0 handed off, then I1 next edge, and fetch resumes at I1's address+4.
- Redirect in flight: target=32'h200 while the request to 0x108 is waiting -> imem_addr stays 108 until ready, that data is discarded, next request is to 200, and the first valid ins has p4=204.
- Redirect and ready coincident, plus redirect during FULL -> returned and skid data both discarded, ins_valid=0, next request to target.
- IF_ALIGN_CHECK_EN: redirect target=32'h202 -> fetch_fault=1 sticky, imem_req=0, ins_valid=0. Without the macro, the next fetch goes to 200.
